fifo_lane_unpacker: RTL and testbench

//  Drains a first-word-fall-through single-clock FIFO (sc_fifo fwft_dout/empty/rd) and splits each
//  DW_IN-bit word into RATIO = DW_IN/DW_OUT lanes on a valid/ready stream.

---
 rtl/fifo_lane_unpacker.sv | 115 +++++++++++
 tb/tb_fifo_lane_unpacker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_lane_unpacker.sv
// Drains a first-word-fall-through FIFO and emits each wide word as RATIO narrow
// lanes on a valid/ready stream, one lane per clock with no bubble between words.
module fifo_lane_unpacker #(
    parameter int DW_IN     = 64,
    parameter int DW_OUT    = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW_IN-1:0]  fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic              flush,
    output logic [DW_OUT-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              dbg_state
);

    localparam int RATIO = DW_IN / DW_OUT;
    localparam int IW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    generate
        if (!(RATIO == 2 || RATIO == 4 || RATIO == 8) || (RATIO * DW_OUT != DW_IN)) begin : g_bad_cfg
            $error("fifo_lane_unpacker: DW_IN must equal RATIO*DW_OUT with RATIO in {2,4,8}");
        end
    endgenerate

    // Valid/ready: a lane transfers on any rising clk edge where m_valid && m_ready;
    // while m_valid is high and m_ready low, m_data/m_last/m_valid do not change.
    typedef enum logic {
        S_EMPTY  = 1'b0,
        S_LOADED = 1'b1
    } state_t;

    state_t              r_state;
    logic [DW_IN-1:0]    r_word;
    logic [IW-1:0]       r_lane_idx;
    logic [DW_OUT-1:0]   r_m_data;
    logic                r_m_valid;
    logic                r_m_last;

    logic [DW_OUT-1:0]   w_cur_lane [RATIO];
    logic [DW_OUT-1:0]   w_new_lane0;
    logic [IW-1:0]       w_next_idx;
    logic                w_accept;
    logic                w_rd;

    genvar g;
    generate
        for (g = 0; g < RATIO; g++) begin : g_lane
            if (LSB_FIRST) begin : g_lsb
                assign w_cur_lane[g] = r_word[g*DW_OUT +: DW_OUT];
            end else begin : g_msb
                assign w_cur_lane[g] = r_word[DW_IN-(g+1)*DW_OUT +: DW_OUT];
            end
        end
        if (LSB_FIRST) begin : g_new_lsb
            assign w_new_lane0 = fifo_dout[DW_OUT-1:0];
        end else begin : g_new_msb
            assign w_new_lane0 = fifo_dout[DW_IN-1 -: DW_OUT];
        end
    endgenerate

    assign w_next_idx = r_lane_idx + IW'(1);
    assign w_accept   = r_m_valid & m_ready;
    // Pop only when a word slot is free: nothing held, or the last lane leaves now.
    assign w_rd       = !rst && !flush && !fifo_empty &&
                        ((r_state == S_EMPTY) || (w_accept && r_m_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_word     <= '0;
            r_lane_idx <= '0;
            r_m_data   <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
        end else if (flush) begin
            r_state    <= S_EMPTY;
            r_lane_idx <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
        end else if (w_rd) begin
            r_word     <= fifo_dout;
            r_m_data   <= w_new_lane0;
            r_m_valid  <= 1'b1;
            r_m_last   <= 1'b0;
            r_lane_idx <= '0;
            r_state    <= S_LOADED;
        end else if (r_state == S_EMPTY) begin
            r_m_valid  <= 1'b0;
        end else if (w_accept) begin
            if (!r_m_last) begin
                r_lane_idx <= w_next_idx;
                r_m_data   <= w_cur_lane[w_next_idx];
                r_m_last   <= (w_next_idx == IW'(RATIO - 1));
            end else begin
                r_m_valid  <= 1'b0;
                r_m_last   <= 1'b0;
                r_state    <= S_EMPTY;
            end
        end
    end

    assign fifo_rd   = w_rd;
    assign m_data    = r_m_data;
    assign m_valid   = r_m_valid;
    assign m_last    = r_m_last;
    assign busy      = r_m_valid | (r_state == S_LOADED);
    assign dbg_state = (r_state == S_LOADED);

endmodule

// File: tb/tb_fifo_lane_unpacker.sv
// Directed bench for fifo_lane_unpacker: a queue-backed FWFT FIFO model feeds
// hand-chosen words; every lane, pop and flag is checked cycle by cycle.
module tb_fifo_lane_unpacker;

    logic        clk;
    logic        rst;
    logic [63:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        flush;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic        dbg_state;

    logic [63:0] fifo_q[$];
    int          n_checks;
    int          n_fail;
    int          rd_count;

    fifo_lane_unpacker #(
        .DW_IN(64),
        .DW_OUT(16),
        .LSB_FIRST(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd(fifo_rd),
        .flush(flush),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last(m_last),
        .busy(busy),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fifo_refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 64'h0;
    endtask

    task automatic fifo_push(input logic [63:0] w);
        fifo_q.push_back(w);
        fifo_refresh();
    endtask

    // Advance one clock: apply the pop the DUT requested, then update the FIFO view.
    task automatic tick();
        logic rd;
        logic emp;
        rd  = fifo_rd;
        emp = fifo_empty;
        check_eq("no_underflow", {63'h0, rd & emp}, 64'h0);
        @(posedge clk);
        if (rd && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            rd_count++;
        end
        #1;
        fifo_refresh();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_beat(input string tag, input logic [15:0] d, input logic last, input logic rd);
        settle();
        check_eq({tag, "_valid"}, {63'h0, m_valid}, 64'h1);
        check_eq({tag, "_data"}, {48'h0, m_data}, {48'h0, d});
        check_eq({tag, "_last"}, {63'h0, m_last}, {63'h0, last});
        check_eq({tag, "_rd"}, {63'h0, fifo_rd}, {63'h0, rd});
        tick();
    endtask

    task automatic expect_idle(input string tag, input logic rd);
        settle();
        check_eq({tag, "_valid"}, {63'h0, m_valid}, 64'h0);
        check_eq({tag, "_last"}, {63'h0, m_last}, 64'h0);
        check_eq({tag, "_rd"}, {63'h0, fifo_rd}, {63'h0, rd});
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rd_count = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        m_ready  = 1'b1;
        fifo_refresh();

        // 1: reset held two cycles with a word waiting
        fifo_push(64'h4444_3333_2222_1111);
        for (int i = 0; i < 2; i++) begin
            settle();
            check_eq("rst_rd", {63'h0, fifo_rd}, 64'h0);
            tick();
            check_eq("rst_valid", {63'h0, m_valid}, 64'h0);
            check_eq("rst_data", {48'h0, m_data}, 64'h0);
            check_eq("rst_last", {63'h0, m_last}, 64'h0);
            check_eq("rst_busy", {63'h0, busy}, 64'h0);
            check_eq("rst_state", {63'h0, dbg_state}, 64'h0);
        end

        // 2: single word, LSB lane first, one pop
        rst = 1'b0;
        expect_idle("w1_load", 1'b1);
        expect_beat("w1_l0", 16'h1111, 1'b0, 1'b0);
        expect_beat("w1_l1", 16'h2222, 1'b0, 1'b0);
        expect_beat("w1_l2", 16'h3333, 1'b0, 1'b0);
        expect_beat("w1_l3", 16'h4444, 1'b1, 1'b0);
        check_eq("w1_rd_count", rd_count, 1);

        // 5: FIFO runs dry, then refills; valid one cycle after the pop
        expect_idle("dry0", 1'b0);
        expect_idle("dry1", 1'b0);
        settle();
        check_eq("dry_busy", {63'h0, busy}, 64'h0);

        // 3: two words back to back, second pop with the last lane
        fifo_push(64'h8888_7777_6666_5555);
        fifo_push(64'hCCCC_BBBB_AAAA_9999);
        expect_idle("w2_load", 1'b1);
        expect_beat("w2_l0", 16'h5555, 1'b0, 1'b0);
        expect_beat("w2_l1", 16'h6666, 1'b0, 1'b0);
        expect_beat("w2_l2", 16'h7777, 1'b0, 1'b0);
        expect_beat("w2_l3", 16'h8888, 1'b1, 1'b1);
        expect_beat("w3_l0", 16'h9999, 1'b0, 1'b0);
        expect_beat("w3_l1", 16'hAAAA, 1'b0, 1'b0);
        expect_beat("w3_l2", 16'hBBBB, 1'b0, 1'b0);
        expect_beat("w3_l3", 16'hCCCC, 1'b1, 1'b0);
        expect_idle("w3_done", 1'b0);
        check_eq("w3_rd_count", rd_count, 3);

        // 4: downstream stalls on lane 2 for three cycles
        fifo_push(64'h4444_3333_2222_1111);
        expect_idle("w4_load", 1'b1);
        expect_beat("w4_l0", 16'h1111, 1'b0, 1'b0);
        expect_beat("w4_l1", 16'h2222, 1'b0, 1'b0);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_beat("w4_stall", 16'h3333, 1'b0, 1'b0);
        end
        m_ready = 1'b1;
        expect_beat("w4_l2", 16'h3333, 1'b0, 1'b0);
        expect_beat("w4_l3", 16'h4444, 1'b1, 1'b0);
        expect_idle("w4_done", 1'b0);

        // 6: flush while lane 1 is presented; next word restarts at lane 0
        fifo_push(64'h4444_3333_2222_1111);
        fifo_push(64'hFFFF_EEEE_DDDD_CCCC);
        expect_idle("w6_load", 1'b1);
        expect_beat("w6_l0", 16'h1111, 1'b0, 1'b0);
        flush = 1'b1;
        expect_beat("w6_flush", 16'h2222, 1'b0, 1'b0);
        flush = 1'b0;
        settle();
        check_eq("flush_busy", {63'h0, busy}, 64'h0);
        check_eq("flush_state", {63'h0, dbg_state}, 64'h0);
        expect_idle("w7_load", 1'b1);
        expect_beat("w7_l0", 16'hCCCC, 1'b0, 1'b0);
        expect_beat("w7_l1", 16'hDDDD, 1'b0, 1'b0);
        expect_beat("w7_l2", 16'hEEEE, 1'b0, 1'b0);
        expect_beat("w7_l3", 16'hFFFF, 1'b1, 1'b0);
        expect_idle("w7_done", 1'b0);

        // flush while idle with a word waiting: no pop in the flush cycle
        fifo_push(64'h0123_4567_89AB_CDEF);
        flush = 1'b1;
        expect_idle("w8_flush", 1'b0);
        flush = 1'b0;
        expect_idle("w8_load", 1'b1);
        expect_beat("w8_l0", 16'hCDEF, 1'b0, 1'b0);
        expect_beat("w8_l1", 16'h89AB, 1'b0, 1'b0);
        expect_beat("w8_l2", 16'h4567, 1'b0, 1'b0);
        expect_beat("w8_l3", 16'h0123, 1'b1, 1'b0);
        expect_idle("w8_done", 1'b0);

        check_eq("total_rd_count", rd_count, 7);
        check_eq("fifo_drained", fifo_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
